// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: load-use bubbles, branch flushes and memory-wait holds.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int LU_STALLS    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] idex_rd,
    input  logic       idex_memread,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       pipe_hold,
    output logic       stall_active,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mw_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [1:0] LU_INIT = 2'(LU_STALLS - 1);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

    state_t     state, nstate;
    logic [1:0] cnt, ncnt;
    logic       lu, lu_ev, br_ev;

    assign lu = idex_memread && (idex_rd != 5'd0) &&
                ((id_use_rs1 && (idex_rd == id_rs1)) || (id_use_rs2 && (idex_rd == id_rs2)));

    always_comb begin
        nstate       = state;
        ncnt         = cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        lu_ev        = 1'b0;
        br_ev        = 1'b0;
        if (rst) begin
            nstate = RUN;
            ncnt   = 2'd0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            nstate      = MEM_WAIT;
        end else if (state == MEM_WAIT) begin
            // Release cycle: run normally; held branch/load are re-evaluated from RUN.
            nstate = RUN;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            br_ev        = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                nstate = FLUSH;
                ncnt   = FL_INIT;
            end else begin
                nstate = RUN;
                ncnt   = 2'd0;
            end
        end else begin
            case (state)
                FLUSH: begin
                    if_id_flush = 1'b1;
                    ncnt        = cnt - 2'd1;
                    if (cnt <= 2'd1) nstate = RUN;
                end
                LU_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    lu_ev        = 1'b1;
                    ncnt         = cnt - 2'd1;
                    if (cnt <= 2'd1) nstate = RUN;
                end
                default: begin
                    if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        lu_ev        = 1'b1;
                        if (LU_STALLS > 1) begin
                            nstate = LU_STALL;
                            ncnt   = LU_INIT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= 2'd0;
            stall_active <= 1'b0;
        end else begin
            state        <= nstate;
            cnt          <= ncnt;
            stall_active <= (nstate != RUN);
        end
    end

    assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt <= '0;
            br_cnt <= '0;
            mw_cnt <= '0;
        end else begin
            if (lu_ev && lu_cnt != CNT_MAX)     lu_cnt <= lu_cnt + 1'b1;
            if (br_ev && br_cnt != CNT_MAX)     br_cnt <= br_cnt + 1'b1;
            if (pipe_hold && mw_cnt != CNT_MAX) mw_cnt <= mw_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 8-bit RISC-V core. Sits beside the forwarding logic in ID/EX.
- Detects load-use hazards, taken-branch redirects and data-memory wait states.
- Drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and the EX/MEM hold.
- Owns a small FSM so that multi-cycle stalls, flushes and memory waits are sequenced with a fixed priority.

Parameters:
- LU_STALLS, 1: bubble cycles inserted per load-use hazard (1..3).
- FLUSH_CYCLES, 1: cycles IF/ID flush stays asserted after a taken branch (1..3).
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- idex_rd  in  5  rd of the instruction in EX.
- idex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_busy  in  1  data memory not ready; MEM stage must hold.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  load NOP into ID/EX.
- pipe_hold  out  1  freeze ID/EX and EX/MEM (memory wait).
- stall_active  out  1  high in any state other than RUN.
- state_o  out  2  current FSM state (debug).

Interface decision: one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- States: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3. A down-counter cnt (2 bits) holds remaining cycles.
- Outputs are combinational from state plus the current inputs. Hazard response therefore takes effect in the detection cycle (0-cycle latency).
- Load-use hazard (lu): idex_memread && idex_rd!=0 && ((id_use_rs1 && idex_rd==id_rs1) || (id_use_rs2 && idex_rd==id_rs2)).
- Event priority, every state: mem_busy > ex_branch_taken > lu.
- Default (RUN, no event): pc_write=1, if_id_write=1, all other outputs 0.
- mem_busy=1, any state:
  - pc_write=0, if_id_write=0, pipe_hold=1, flush=0, bubble=0.
  - Next state MEM_WAIT; cnt is preserved.
- MEM_WAIT:
  - Outputs as above while mem_busy=1.
  - When mem_busy=0, outputs as RUN for that cycle and next state RUN. The frozen branch/load are re-evaluated from RUN.
- ex_branch_taken=1 (mem_busy=0), from RUN or LU_STALL:
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - Branch preempts any load-use stall.
  - If FLUSH_CYCLES>1: next state FLUSH, cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- FLUSH:
  - if_id_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0.
  - cnt decrements each cycle; at cnt==1 the next state is RUN.
  - lu is ignored, since ID holds a flushed NOP.
- lu=1 in RUN (no higher event):
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LU_STALLS>1: next state LU_STALL, cnt=LU_STALLS-1. Otherwise stay in RUN; the next cycle re-checks with updated idex_*.
- LU_STALL:
  - Same outputs as an lu stall in RUN; cnt decrements; cnt==1 leads to RUN.
- stall_active is the registered comparison state!=RUN.
- Async reset mid-operation: state=RUN, cnt=0 and counters=0 immediately. Outputs take RUN defaults while rst is high.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds ports lu_cnt, br_cnt, mw_cnt (each CNT_W bits, out).
  - lu_cnt increments once per cycle with id_ex_bubble due to lu.
  - br_cnt increments once per taken-branch event.
  - mw_cnt increments per cycle with pipe_hold=1.
  - All counters saturate at all-ones and reset to 0.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Load-use, LU_STALLS=1: idex_memread=1, idex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; next cycle (idex_memread=0) RUN defaults.
- x0 and unused operands: idex_rd=0=id_rs1 with load; then idex_rd=7=id_rs2 with id_use_rs2=0 -> no stall, pc_write=1 in both cycles.
- Branch beats load-use, FLUSH_CYCLES=2: ex_branch_taken=1 together with lu -> if_id_flush=1, id_ex_bubble=1, pc_write=1; next cycle state_o=2, if_id_flush=1; then state_o=0.
- Memory wait: mem_busy=1 for 3 cycles during LU_STALL (LU_STALLS=3, cnt=2) -> pipe_hold=1 and pc_write=0 for 3 cycles, state_o=3; on release, RUN outputs.
- Async reset mid-FLUSH: rst asserted between clock edges -> state_o=0 and stall_active=0 immediately, with no clock edge required.
- With HAZARD_PERF_CNT_EN: 2 lu stalls, 1 branch and 4 busy cycles -> lu_cnt=2, br_cnt=1, mw_cnt=4; CNT_W=2 with 5 busy cycles -> mw_cnt=3 (saturated).
